sumador_enable_gen: RTL and testbench
=====================================

# sumador_enable_gen

Upstream stage for the counter adder (`sumador`). It turns a raw, bouncing push-button into a clean, single-cycle `enable` strobe for the counter:
- 2-flop synchronizer, then a stability-counter debouncer.
- Press FSM with optional auto-repeat: holding the button advances the counter at a fixed rate.
- The top level drives `ui_in[0]` through this block into the counter's `enable`.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles needed to accept a level change. Range 2..65535.
- `REPEAT_DELAY`, default 64: cycles from the first strobe to the first auto-repeat strobe. Range 2..65535.
- `REPEAT_PERIOD`, default 16: cycles between subsequent auto-repeat strobes. Range 2..65535.

Ports:
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `btn_in` in 1: raw asynchronous button, active-high.
- `auto_repeat` in 1: 1 enables auto-repeat while held. Sampled every cycle; no synchronizer.
- `enable_o` out 1: one-cycle strobe to the counter `enable`.
- `btn_level` out 1: debounced button level.
- `repeating` out 1: high while the FSM is in REPEAT.

## Operation

Synchronizer:
- `btn_in` passes through `sync1` → `sync2`.
- Only `sync2` is used downstream.

Debouncer:
- 16-bit `stab_cnt`.
- When `sync2 == btn_level`: `stab_cnt` clears to 0.
- Otherwise `stab_cnt` increments. When it reaches `DEBOUNCE_CYCLES-1` while still differing, `btn_level` takes `sync2` and `stab_cnt` clears.
- Any glitch back to the old level restarts the count from 0.

FSM (states IDLE, WAIT_REP, REPEAT, HELD); `rise` / `fall` are the edges of `btn_level`:
- IDLE:
  - On `rise`: pulse `enable_o`. Go to WAIT_REP if `auto_repeat`=1, else HELD.
  - The 16-bit timer loads 0.
- WAIT_REP: timer increments. At `REPEAT_DELAY-1`, pulse `enable_o`, go to REPEAT, timer loads 0.
- REPEAT: timer increments. At `REPEAT_PERIOD-1`, pulse `enable_o` and timer loads 0.
- HELD: no strobes. Waits for release.
- From any non-IDLE state:
  - `fall` → IDLE, no strobe. Release has priority over a same-cycle timer expiry; no strobe on that cycle.
  - `auto_repeat`=0 in WAIT_REP or REPEAT → HELD. Re-asserting it does not resume repeat until the next press.

Strobe rules:
- `enable_o` is registered. It is never high for two consecutive cycles (all periods ≥2).
- `repeating` = (state == REPEAT), registered.

## Timing

Reset values (on a `rst_n`=0 edge):
- `sync1`, `sync2`, `btn_level`, `stab_cnt`, timer, `enable_o`, `repeating` = 0.
- State = IDLE.

Latency:
- Let E0 be the first edge sampling `btn_in`=1, with the input then held.
- `sync2`=1 after E0+1.
- `btn_level`=1 after edge E0+1+`DEBOUNCE_CYCLES`.
- `enable_o` high for exactly one cycle after edge E0+2+`DEBOUNCE_CYCLES`.
- Release latency to `btn_level`=0 is the same.

Repeat spacing:
- First-to-second strobe: `REPEAT_DELAY` cycles apart.
- Thereafter: `REPEAT_PERIOD` cycles apart.

Reset mid-operation:
- Any in-flight strobe is cancelled and state returns to IDLE.
- If the button is still held after reset, it is treated as a new press: a strobe follows after the full debounce latency.

Bounce rule: pulses shorter than `DEBOUNCE_CYCLES` cycles on `sync2` never change `btn_level` and never produce a strobe.

## Test plan

Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=3.

1. Reset and single press:
   - Stimulus: hold `rst_n`=0 for 3 cycles, release. With `auto_repeat`=0, raise `btn_in` at E0 and hold for 20 cycles.
   - Response: all outputs 0 during reset. `btn_level`↑ after E0+5. Exactly one `enable_o` pulse, after E0+6. No further strobes.
2. Bounce rejection:
   - Stimulus: `btn_in` toggles 1,0,1,1,0,1 on consecutive edges, then holds 1.
   - Response: no `enable_o` during the bounce. Exactly one strobe, 6 edges after the last 0→1 transition.
3. Auto-repeat:
   - Stimulus: `auto_repeat`=1, hold the button for 30 cycles after the first strobe at cycle P.
   - Response: strobes at P, P+8, P+11, P+14, … `repeating`=1 from P+8.
4. Release and timer collision:
   - Stimulus: release so that `btn_level` falls on the same cycle a REPEAT strobe would fire.
   - Response: no strobe on that cycle, state IDLE, `repeating`=0 on the next cycle.
5. auto_repeat drop:
   - Stimulus: deassert `auto_repeat` in WAIT_REP at P+3, re-assert at P+5, keep holding.
   - Response: no strobes after P until the next press.
6. Reset mid-hold:
   - Stimulus: pulse `rst_n`=0 for 1 cycle while in REPEAT, with the button still held.
   - Response: outputs 0 the next cycle. A new strobe occurs 6 edges after reset release (sync refill plus debounce).

Source files
------------

// File: rtl/sumador_enable_gen.sv
// ---------------------------------------------------------------------------
// sumador_enable_gen
//
// Purpose: turns a raw, bouncing push-button into a clean single-cycle
// enable strobe for the counter adder. The button is synchronized (2 flops),
// debounced with a stability counter, and fed to a press FSM that strobes
// once per press and optionally auto-repeats while the button is held.
//
// Ports:
//   clk          in  1  single clock, rising edge
//   rst_n        in  1  synchronous, active-low reset
//   btn_in       in  1  raw asynchronous button, active-high
//   auto_repeat  in  1  1 = auto-repeat while held (sampled every cycle)
//   enable_o     out 1  registered one-cycle strobe to the counter enable
//   btn_level    out 1  debounced button level
//   repeating    out 1  high while the FSM is in REPEAT (registered)
//
// Handshake: enable_o is a plain strobe with no ready/back-pressure; the
// counter consumes it on the cycle it is high. Every period is at least 2,
// so the strobe is never high on two consecutive cycles.
// ---------------------------------------------------------------------------
module sumador_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic auto_repeat,
    output logic enable_o,
    output logic btn_level,
    output logic repeating
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_REP = 2'd1;
    localparam logic [1:0] REPEAT   = 2'd2;
    localparam logic [1:0] HELD     = 2'd3;

    localparam logic [15:0] DB_LAST  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] RD_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RP_LAST  = 16'(REPEAT_PERIOD - 1);

    logic        sync1;
    logic        sync2;
    logic [15:0] stab_cnt;
    logic        level_d;
    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [15:0] timer;
    logic [15:0] timer_nx;
    logic        strobe_nx;
    logic        rise;
    logic        fall;

    // Synchronizer and stability-counter debouncer. The level only flips
    // after DEBOUNCE_CYCLES consecutive cycles of disagreement; any cycle of
    // agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            stab_cnt  <= 16'd0;
            btn_level <= 1'b0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
            if (sync2 == btn_level) begin
                stab_cnt <= 16'd0;
            end else if (stab_cnt == DB_LAST) begin
                btn_level <= sync2;
                stab_cnt  <= 16'd0;
            end else begin
                stab_cnt <= stab_cnt + 16'd1;
            end
        end
    end

    // Edges of the debounced level, seen one cycle after btn_level moves.
    assign rise = btn_level & ~level_d;
    assign fall = ~btn_level & level_d;

    // Press FSM. In the timed states a release wins over a timer expiry,
    // and dropping auto_repeat wins over an expiry as well.
    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        strobe_nx = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = 16'd0;
                if (rise) begin
                    strobe_nx = 1'b1;
                    state_nx  = auto_repeat ? WAIT_REP : HELD;
                end
            end
            WAIT_REP: begin
                if (fall) begin
                    state_nx = IDLE;
                    timer_nx = 16'd0;
                end else if (!auto_repeat) begin
                    state_nx = HELD;
                    timer_nx = 16'd0;
                end else if (timer == RD_LAST) begin
                    strobe_nx = 1'b1;
                    state_nx  = REPEAT;
                    timer_nx  = 16'd0;
                end else begin
                    timer_nx = timer + 16'd1;
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_nx = IDLE;
                    timer_nx = 16'd0;
                end else if (!auto_repeat) begin
                    state_nx = HELD;
                    timer_nx = 16'd0;
                end else if (timer == RP_LAST) begin
                    strobe_nx = 1'b1;
                    timer_nx  = 16'd0;
                end else begin
                    timer_nx = timer + 16'd1;
                end
            end
            HELD: begin
                timer_nx = 16'd0;
                if (fall) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= 16'd0;
            enable_o  <= 1'b0;
            repeating <= 1'b0;
            level_d   <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            enable_o  <= strobe_nx;
            repeating <= (state_nx == REPEAT);
            level_d   <= btn_level;
        end
    end

endmodule

// File: tb/tb_sumador_enable_gen.sv
module tb_sumador_enable_gen;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic auto_repeat = 1'b0;
  logic enable_o;
  logic btn_level;
  logic repeating;

  always #5 clk = ~clk;

  sumador_enable_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .auto_repeat(auto_repeat),
    .enable_o(enable_o),
    .btn_level(btn_level),
    .repeating(repeating)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int strobe_q[$];
  int lvl_rise_cyc = -1;
  logic mon_level_prev = 1'b0;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Sync is two samples of delay; the level flips after DB consecutive
  // disagreeing samples; a press strobes at offset 0 and, while still armed,
  // at RD, RD+RP, RD+2RP ... cycles after it.
  bit m_s1, m_s2, m_level, m_level_prev;
  int m_run;
  bit m_pressed, m_armed;
  int m_k;

  task automatic model_step();
    bit en;
    bit rep;
    en = 1'b0;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_level_prev = 0; m_run = 0;
      m_pressed = 0; m_armed = 0; m_k = 0;
    end else begin
      if (m_level && !m_level_prev) begin
        m_pressed = 1; m_k = 0; m_armed = auto_repeat; en = 1'b1;
      end else if (m_pressed) begin
        if (!m_level && m_level_prev) begin
          m_pressed = 0; m_armed = 0;
        end else begin
          m_k++;
          if (!auto_repeat) m_armed = 0;
          else if (m_armed && m_k >= RD && ((m_k - RD) % RP) == 0) en = 1'b1;
        end
      end
      m_level_prev = m_level;
      if (m_s2 != m_level) begin
        m_run++;
        if (m_run == DB) begin
          m_level = m_s2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
    rep = m_pressed && m_armed && (m_k >= RD);
    exp_q.push_back({en, rep, m_level});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("enable_o", int'(enable_o), int'(e[2]));
        check("repeating", int'(repeating), int'(e[1]));
        check("btn_level", int'(btn_level), int'(e[0]));
      end
      if (enable_o === 1'b1) strobe_q.push_back(cyc);
      if (btn_level === 1'b1 && mon_level_prev === 1'b0) lvl_rise_cyc = cyc;
      mon_level_prev = btn_level;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    for (int g = 0; g < 2000 && cyc < target; g++) @(negedge clk);
    check("wait_until_reached", int'(cyc >= target), 1);
  endtask

  task automatic release_btn();
    btn_in = 1'b0;
    tick(12);
  endtask

  // ---------------- directed scenarios + random phase ----------------
  initial begin
    int e0;
    int p;
    int r;
    int exp_s[$];
    int len;
    logic [5:0] bounce;

    // 1: reset and single press
    rst_n = 1'b0; btn_in = 1'b0; auto_repeat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_enable", int'(enable_o), 0);
      check("rst_level", int'(btn_level), 0);
      check("rst_repeating", int'(repeating), 0);
    end
    rst_n = 1'b1;
    tick(2);
    strobe_q.delete();
    btn_in = 1'b1;
    e0 = cyc + 1;
    tick(20);
    check("s1_level_rise_cyc", lvl_rise_cyc, e0 + 5);
    check("s1_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check("s1_strobe_cyc", strobe_q[0], e0 + 6);
    release_btn();

    // 2: bounce rejection, sequence applied oldest bit first
    strobe_q.delete();
    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      btn_in = bounce[i];
      e0 = cyc + 1;
      @(negedge clk);
    end
    tick(20);
    check("s2_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check("s2_strobe_cyc", strobe_q[0], e0 + 6);
    release_btn();

    // 3 + 4: auto-repeat, then a release that collides with a repeat expiry
    strobe_q.delete();
    auto_repeat = 1'b1;
    btn_in = 1'b1;
    e0 = cyc + 1;
    p = e0 + 6;
    wait_until(p + 28);
    btn_in = 1'b0;
    wait_until(p + 34);
    check("s4_repeating_before_fall", int'(repeating), 1);
    tick(1);
    check("s4_no_strobe_on_collision", int'(enable_o), 0);
    check("s4_repeating_after_fall", int'(repeating), 0);
    tick(4);
    exp_s.delete();
    exp_s.push_back(p);
    for (int t = p + RD; t <= p + 32; t += RP) exp_s.push_back(t);
    check("s3_strobe_count", strobe_q.size(), exp_s.size());
    for (int i = 0; i < exp_s.size() && i < strobe_q.size(); i++)
      check("s3_strobe_cyc", strobe_q[i], exp_s[i]);
    tick(4);

    // 5: auto_repeat drop in WAIT_REP
    strobe_q.delete();
    btn_in = 1'b1;
    e0 = cyc + 1;
    p = e0 + 6;
    wait_until(p + 2);
    auto_repeat = 1'b0;
    tick(2);
    auto_repeat = 1'b1;
    wait_until(p + 30);
    check("s5_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check("s5_strobe_cyc", strobe_q[0], p);
    release_btn();

    // 6: reset mid-hold while repeating
    btn_in = 1'b1;
    e0 = cyc + 1;
    p = e0 + 6;
    wait_until(p + 9);
    check("s6_in_repeat", int'(repeating), 1);
    strobe_q.delete();
    rst_n = 1'b0;
    r = cyc + 1;
    tick(1);
    check("s6_rst_enable", int'(enable_o), 0);
    check("s6_rst_level", int'(btn_level), 0);
    check("s6_rst_repeating", int'(repeating), 0);
    rst_n = 1'b1;
    tick(10);
    check("s6_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check("s6_strobe_cyc", strobe_q[0], r + 7);
    release_btn();

    // random phase: bursts of random length (short ones bounce), random
    // auto_repeat toggles and rare resets, all checked against the model
    for (int i = 0; i < 3000; ) begin
      len = $urandom_range(1, 30);
      btn_in = ~btn_in;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 19) == 0) auto_repeat = ~auto_repeat;
        rst_n = ($urandom_range(0, 399) != 0);
        @(negedge clk);
        i++;
      end
    end
    rst_n = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
